wb_cmd_bridge: RTL and testbench
================================

WB_CMD_BRIDGE -- requirements
Module: wb_cmd_bridge

Interface
REQ-001 The block SHALL use clock clk and reset rst; reset rst, synchronous, active-high; clock clk.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, SHALL set the maximum number of cycles spent waiting for a bus acknowledge.
REQ-003 Ports SHALL be, as name  direction  width  meaning:
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous active-high reset
- cmd_stb  in  1  command strobe; held high 1 or more cycles per command
- adr  in  8  register address (0x00 TX, 0x10 CTRL, 0x14 DIVIDE, 0x18 SS)
- cmd_word  in  34  [32]=1 write / 0 read; [31:0] write data; [33] reserved, ignored
- wb_cyc_o, wb_stb_o  out  1  Wishbone cycle/strobe to SPI master
- wb_we_o  out  1  write enable
- wb_adr_o  out  8  address
- wb_dat_o  out  32  write data
- wb_sel_o  out  4  byte select
- wb_dat_i  in  32  read data
- wb_ack_i  in  1  acknowledge
- rd_data  out  32  last read result
- rd_valid  out  1  one-cycle pulse, rd_data updated
- busy  out  1  queue non-empty or bus cycle open
- cmd_overflow  out  1  one-cycle pulse, command dropped
- timeout_err  out  1  one-cycle pulse, bus cycle aborted

Function
REQ-004 A command SHALL be accepted only on a rising edge of cmd_stb (cmd_stb=1 and registered previous cmd_stb=0); a strobe held for N cycles yields exactly one command.
REQ-005 On acceptance, {adr, cmd_word[32:0]} SHALL be written into a 4-entry FIFO at that same posedge.
REQ-006 If the FIFO holds 4 entries at acceptance, the command SHALL be discarded and cmd_overflow pulsed for one cycle; FIFO contents unchanged.
REQ-007 Simultaneous push and pop SHALL be permitted when the FIFO is full or non-full; occupancy unchanged; order strictly FIFO.
REQ-008 State machine SHALL have states IDLE and BUS.
REQ-009 IDLE: if FIFO non-empty, pop head, register wb_adr_o, wb_we_o=cmd[32], wb_dat_o=cmd[31:0], set wb_cyc_o=wb_stb_o=1, go BUS; else remain.
REQ-010 Latency: command accepted at edge E0 SHALL have wb_cyc_o high after edge E1.
REQ-011 BUS: on edge with wb_ack_i=1, clear wb_cyc_o/wb_stb_o and go IDLE; if wb_we_o=0, load rd_data from wb_dat_i and pulse rd_valid.
REQ-012 BUS: timeout counter SHALL clear on entry, increment each BUS cycle without ack; at count TIMEOUT_CYCLES without ack, clear wb_cyc_o/wb_stb_o, pulse timeout_err, go IDLE, rd_data unchanged.
REQ-013 Ack and timeout on the same edge SHALL be treated as ack only.
REQ-014 Consecutive bus cycles SHALL be separated by exactly one IDLE cycle with wb_cyc_o=0.
REQ-015 wb_sel_o SHALL be constant 4'hF; wb_stb_o SHALL equal wb_cyc_o.
REQ-016 wb_ack_i while in IDLE SHALL be ignored.
REQ-017 busy SHALL be 1 when state=BUS or FIFO non-empty.

Reset
REQ-018 On rst: state IDLE, FIFO empty, strobe history 0, wb_cyc_o/wb_stb_o/wb_we_o 0, wb_adr_o 0, wb_dat_o 0, rd_data 0, all pulses 0, busy 0.
REQ-019 rst during BUS SHALL drop wb_cyc_o after that edge and discard queued commands; no rd_valid or timeout_err.
REQ-020 cmd_stb held high through reset release SHALL NOT produce a command until it falls and rises again.

Verification
REQ-021 Write: adr=0x14, cmd_word=34'h100000000, cmd_stb high 2 cycles, ack 2 cycles after stb -> exactly one cycle, wb_adr_o=0x14, wb_we_o=1, wb_dat_o=0.
REQ-022 Read: adr=0x10, cmd_word=0, ack with wb_dat_i=0x00003010 -> rd_valid one cycle, rd_data=0x00003010.
REQ-023 Init sequence: writes 0x14/0x0, 0x10/0x3010, 0x18/0x1 strobed back-to-back, ack 1 cycle late -> three bus cycles in order, one IDLE gap each.
REQ-024 Overflow: ack held low, 6 commands -> 1 in BUS, 4 queued, 6th drops with one cmd_overflow pulse.
REQ-025 Timeout: TIMEOUT_CYCLES=16, no ack -> cyc drops after 16 BUS cycles, one timeout_err pulse, next queued command issues.
REQ-026 Reset mid-BUS with 2 queued -> cyc low after edge, busy 0, no further bus cycles.

Source files
------------

// File: rtl/wb_cmd_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_cmd_bridge : strobed command queue issuing single Wishbone cycles     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module wb_cmd_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_stb,
  input  logic [7:0]  adr,
  input  logic [33:0] cmd_word,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [7:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        cmd_overflow,
  output logic        timeout_err
);

  localparam int c_tmo_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_t;

  state_t              r_state;
  logic                r_stb_q;
  logic                r_armed;
  logic [40:0]         r_mem [4];
  logic [1:0]          r_wr_ptr;
  logic [1:0]          r_rd_ptr;
  logic [2:0]          r_count;
  logic [c_tmo_w-1:0]  r_tmo_cnt;
  logic                r_cyc;
  logic                r_we;
  logic [7:0]          r_adr;
  logic [31:0]         r_dat;
  logic [31:0]         r_rd_data;
  logic                r_rd_valid;
  logic                r_ovf;
  logic                r_tmo_err;

  logic                w_accept;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic [40:0]         w_head;
  logic                w_unused_rsvd;

  assign w_unused_rsvd = cmd_word[33];

  // r_armed stays low after reset until the strobe is seen low, so a strobe
  // held through reset release is not taken as a new command.
  assign w_accept = cmd_stb & ~r_stb_q & r_armed;
  assign w_full   = (r_count == 3'd4);
  assign w_pop    = (r_state == ST_IDLE) && (r_count != 3'd0);
  assign w_push   = w_accept & (~w_full | w_pop);
  assign w_head   = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {adr, cmd_word[32:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_stb_q    <= 1'b0;
      r_armed    <= ~cmd_stb;
      r_wr_ptr   <= 2'd0;
      r_rd_ptr   <= 2'd0;
      r_count    <= 3'd0;
      r_tmo_cnt  <= '0;
      r_cyc      <= 1'b0;
      r_we       <= 1'b0;
      r_adr      <= 8'd0;
      r_dat      <= 32'd0;
      r_rd_data  <= 32'd0;
      r_rd_valid <= 1'b0;
      r_ovf      <= 1'b0;
      r_tmo_err  <= 1'b0;
    end else begin
      r_stb_q    <= cmd_stb;
      if (!cmd_stb) begin
        r_armed <= 1'b1;
      end
      r_rd_valid <= 1'b0;
      r_tmo_err  <= 1'b0;
      r_ovf      <= w_accept & w_full & ~w_pop;

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 3'd1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 3'd1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_adr     <= w_head[40:33];
            r_we      <= w_head[32];
            r_dat     <= w_head[31:0];
            r_cyc     <= 1'b1;
            r_tmo_cnt <= '0;
            r_state   <= ST_BUS;
          end
        end
        ST_BUS: begin
          // Ack wins over a timeout landing on the same edge.
          if (wb_ack_i) begin
            r_cyc   <= 1'b0;
            r_state <= ST_IDLE;
            if (!r_we) begin
              r_rd_data  <= wb_dat_i;
              r_rd_valid <= 1'b1;
            end
          end else if (r_tmo_cnt == c_tmo_last) begin
            r_cyc     <= 1'b0;
            r_tmo_err <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
          end
        end
        default: begin
          r_cyc   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign wb_cyc_o     = r_cyc;
  assign wb_stb_o     = r_cyc;
  assign wb_we_o      = r_we;
  assign wb_adr_o     = r_adr;
  assign wb_dat_o     = r_dat;
  assign wb_sel_o     = 4'hF;
  assign rd_data      = r_rd_data;
  assign rd_valid     = r_rd_valid;
  assign cmd_overflow = r_ovf;
  assign timeout_err  = r_tmo_err;
  assign busy         = (r_state == ST_BUS) || (r_count != 3'd0);

endmodule
`default_nettype wire

// File: tb/tb_wb_cmd_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wb_cmd_bridge : randomized + directed bench with queue-based model    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_wb_cmd_bridge;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_stb = 1'b0;
  logic [7:0]  adr = 8'd0;
  logic [33:0] cmd_word = 34'd0;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [7:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i = 32'd0;
  logic        wb_ack_i = 1'b0;
  logic [31:0] rd_data;
  logic        rd_valid, busy, cmd_overflow, timeout_err;

  always #5 clk = ~clk;

  wb_cmd_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .cmd_stb(cmd_stb), .adr(adr), .cmd_word(cmd_word),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .cmd_overflow(cmd_overflow),
    .timeout_err(timeout_err)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a queue of pending commands plus the one on the bus.
  typedef struct packed {
    logic [7:0]  a;
    logic        we;
    logic [31:0] d;
  } cmd_t;

  cmd_t        m_q[$];
  cmd_t        m_cur = '0;
  bit          m_bus = 0;
  int          m_bc = 0;
  logic [31:0] m_rd = 32'd0;
  bit          m_rv = 0, m_to = 0, m_ov = 0, m_last = 0;

  always @(posedge clk) begin : model
    bit acc;
    if (rst) begin
      m_q.delete();
      m_bus = 0; m_bc = 0; m_rd = 32'd0;
      m_rv = 0; m_to = 0; m_ov = 0; m_cur = '0;
      m_last = cmd_stb;
    end else begin
      acc = cmd_stb && !m_last;
      m_last = cmd_stb;
      m_rv = 0; m_to = 0; m_ov = 0;
      if (m_bus) begin
        if (wb_ack_i) begin
          m_bus = 0;
          if (!m_cur.we) begin m_rd = wb_dat_i; m_rv = 1; end
        end else begin
          m_bc++;
          if (m_bc == T) begin m_bus = 0; m_to = 1; end
        end
      end else if (m_q.size() > 0) begin
        m_cur = m_q.pop_front();
        m_bus = 1;
        m_bc = 0;
      end
      if (acc) begin
        if (m_q.size() < 4) m_q.push_back(cmd_t'({adr, cmd_word[32:0]}));
        else m_ov = 1;
      end
    end
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc", wb_cyc_o, m_bus);
      check("stb", wb_stb_o, m_bus);
      check("sel", wb_sel_o, 4'hF);
      check("busy", busy, (m_bus || m_q.size() != 0));
      check("rd_data", rd_data, m_rd);
      check("rd_valid", rd_valid, m_rv);
      check("timeout_err", timeout_err, m_to);
      check("cmd_overflow", cmd_overflow, m_ov);
      if (m_bus) begin
        check("wb_adr", wb_adr_o, m_cur.a);
        check("wb_we", wb_we_o, m_cur.we);
        check("wb_dat", wb_dat_o, m_cur.d);
      end
    end
  end

  // Bus-activity log used by the directed scenarios.
  int          starts = 0, rv_cnt = 0, to_cnt = 0, ov_cnt = 0;
  int          hi_run = 0, lo_run = 0;
  bit          prev_cyc = 0, seen = 0;
  int          hi_len[$];
  int          gaps[$];
  logic [7:0]  adr_log[$];
  logic [31:0] dat_log[$];

  always @(negedge clk) begin
    if (rd_valid) rv_cnt++;
    if (timeout_err) to_cnt++;
    if (cmd_overflow) ov_cnt++;
    if (wb_cyc_o) begin
      if (!prev_cyc) begin
        starts++;
        adr_log.push_back(wb_adr_o);
        dat_log.push_back(wb_dat_o);
        if (seen) gaps.push_back(lo_run);
        seen = 1;
        hi_run = 0;
      end
      hi_run++;
    end else begin
      if (prev_cyc) begin
        hi_len.push_back(hi_run);
        lo_run = 0;
      end
      lo_run++;
    end
    prev_cyc = wb_cyc_o;
  end

  task automatic clear_logs();
    starts = 0; rv_cnt = 0; to_cnt = 0; ov_cnt = 0;
    seen = 0; lo_run = 0;
    hi_len.delete(); gaps.delete(); adr_log.delete(); dat_log.delete();
  endtask

  // Ack responder: 0 = never, 1 = random per cycle, 2 = after ack_dly cycles of cyc.
  int          ack_mode = 0, ack_pct = 50, ack_dly = 1, cyc_age = 0;
  bit          dat_fix = 0;
  logic [31:0] dat_val = 32'd0;

  always @(posedge clk) begin
    #1;
    if (wb_cyc_o) cyc_age++;
    else cyc_age = 0;
    case (ack_mode)
      1:       wb_ack_i = ($urandom_range(0, 99) < ack_pct);
      2:       wb_ack_i = wb_cyc_o && (cyc_age >= ack_dly);
      default: wb_ack_i = 1'b0;
    endcase
    wb_dat_i = dat_fix ? dat_val : $urandom;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] a, input logic [33:0] w, input int hold);
    cmd_stb = 1'b1; adr = a; cmd_word = w;
    repeat (hold) tick();
    cmd_stb = 1'b0;
    adr = 8'($urandom);
    cmd_word = {2'($urandom), $urandom};
    tick();
  endtask

  initial begin
    rst = 1'b1;
    tick();
    chk_en = 1;
    idle(2);
    check("rst_cyc", wb_cyc_o, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_adr", wb_adr_o, 0);
    check("rst_dat", wb_dat_o, 0);
    rst = 1'b0;
    idle(2);

    // Single write, strobe held two cycles.
    ack_mode = 2; ack_dly = 1; clear_logs();
    send(8'h14, 34'h1_0000_0000, 2);
    idle(6);
    check("wr_starts", starts, 1);
    check("wr_len", hi_len[0], 1);
    check("wr_adr", adr_log[0], 8'h14);
    check("wr_dat", dat_log[0], 32'h0);

    // Single read.
    dat_fix = 1; dat_val = 32'h0000_3010; clear_logs();
    send(8'h10, 34'h0, 1);
    idle(6);
    check("rd_pulses", rv_cnt, 1);
    check("rd_value", rd_data, 32'h0000_3010);
    check("model_rd", m_rd, 32'h0000_3010);
    dat_fix = 0;

    // Init sequence, ack one cycle late.
    ack_dly = 2; clear_logs();
    send(8'h14, 34'h1_0000_0000, 1);
    send(8'h10, 34'h1_0000_3010, 1);
    send(8'h18, 34'h1_0000_0001, 1);
    idle(12);
    check("init_starts", starts, 3);
    check("init_adr0", adr_log[0], 8'h14);
    check("init_adr1", adr_log[1], 8'h10);
    check("init_adr2", adr_log[2], 8'h18);
    check("init_dat1", dat_log[1], 32'h3010);
    check("init_dat2", dat_log[2], 32'h1);
    check("init_ngaps", gaps.size(), 2);
    check("init_gap0", gaps[0], 1);
    check("init_gap1", gaps[1], 1);

    // Overflow: six commands with ack held low.
    ack_mode = 0; clear_logs();
    for (int i = 1; i <= 6; i++) send(8'(i), {2'b01, 32'(i)}, 1);
    check("ovf_pulses", ov_cnt, 1);
    check("ovf_starts", starts, 1);
    check("ovf_busy", busy, 1);
    ack_mode = 2; ack_dly = 1;
    idle(20);
    check("ovf_drain", starts, 5);
    check("ovf_last_adr", adr_log[4], 8'h05);
    check("ovf_no_tmo", to_cnt, 0);

    // Timeout with no ack at all.
    ack_mode = 0; clear_logs();
    send(8'h00, 34'h1_1234_5678, 1);
    send(8'h18, 34'h1_0000_0001, 1);
    idle(45);
    check("tmo_pulses", to_cnt, 2);
    check("tmo_starts", starts, 2);
    check("tmo_len0", hi_len[0], 16);
    check("tmo_len1", hi_len[1], 16);
    check("tmo_rd_kept", rd_data, 32'h0000_3010);
    check("tmo_busy", busy, 0);

    // Reset during a bus cycle with two queued.
    ack_mode = 0; clear_logs();
    send(8'h00, 34'h1_0000_00AA, 1);
    send(8'h10, 34'h1_0000_00BB, 1);
    send(8'h14, 34'h1_0000_00CC, 1);
    rst = 1'b1;
    tick();
    check("rstbus_cyc", wb_cyc_o, 0);
    check("rstbus_busy", busy, 0);
    rst = 1'b0; ack_mode = 2;
    idle(15);
    check("rstbus_starts", starts, 1);
    check("rstbus_rv", rv_cnt, 0);
    check("rstbus_tmo", to_cnt, 0);

    // Strobe held through reset release.
    clear_logs();
    rst = 1'b1; cmd_stb = 1'b1; adr = 8'h18; cmd_word = 34'h1_0000_0001;
    idle(2);
    rst = 1'b0;
    idle(3);
    cmd_stb = 1'b0;
    idle(3);
    check("held_starts", starts, 0);
    check("held_busy", busy, 0);
    send(8'h18, 34'h1_0000_0001, 1);
    idle(5);
    check("held_then_new", starts, 1);

    // Randomized traffic with varying ack behaviour.
    for (int p = 0; p < 3; p++) begin
      ack_mode = 1;
      case (p)
        0:       ack_pct = 60;
        1:       ack_pct = 15;
        default: ack_pct = 0;
      endcase
      for (int n = 0; n < 150; n++) begin
        logic [7:0] ra;
        case ($urandom_range(0, 3))
          0:       ra = 8'h00;
          1:       ra = 8'h10;
          2:       ra = 8'h14;
          default: ra = 8'h18;
        endcase
        send(ra, {2'($urandom), $urandom}, $urandom_range(1, 3));
        idle($urandom_range(0, 3));
        if ($urandom_range(0, 199) == 0) begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
        end
      end
    end
    ack_mode = 2; ack_dly = 1;
    idle(40);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
